// File: rtl/data_mem_lsu.sv
// Word-organised data RAM with an RV32I load/store front end (byte/half/word, signed/unsigned).
// Response one cycle after accept, no response backpressure; requests are held off while memory is being zero-filled.
module data_mem_lsu #(
  parameter int DEPTH          = 256,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_clr_idx;
  logic [31:0]   r_mem [DEPTH];

  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic [31:0]   r_rsp_rdata;

  logic          w_acc;
  logic          w_oor;
  logic          w_f3_ok;
  logic          w_misal;
  logic          w_err;
  logic          w_wr;
  logic          w_clr_we;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wdat;
  logic [31:0]   w_rword;
  logic [31:0]   w_shifted;
  logic [31:0]   w_ldat;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    busy        = 1'b0;
    w_clr_we    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        busy     = 1'b1;
        w_clr_we = !rst;
        if (r_clr_idx == AW'(DEPTH - 1)) begin
          w_state_nxt = S_READY;
        end
      end
      S_READY: begin
        req_ready = !rst;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_idx <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_idx <= r_clr_idx + AW'(1);
    end else begin
      r_clr_idx <= '0;
    end
  end

  // ---------------- request decode ----------------
  assign w_acc = req_valid && req_ready;
  assign w_idx = req_addr[AW+1:2];
  assign w_oor = {2'b00, req_addr[31:2]} >= 32'(DEPTH);

  always_comb begin
    w_f3_ok = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = !req_we;
      default:                w_f3_ok = 1'b0;
    endcase
  end

  // Low two funct3 bits encode access size for every legal code (LBU/LHU included).
  assign w_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_err   = w_oor || !w_f3_ok || w_misal;

  // ---------------- store path ----------------
  assign w_wr = w_acc && req_we && !w_err;

  always_comb begin
    w_be   = 4'b1111;
    w_wdat = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_be   = 4'b0001 << req_addr[1:0];
        w_wdat = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = 4'b0011 << req_addr[1:0];
        w_wdat = {2{req_wdata[15:0]}};
      end
      default: begin
        w_be   = 4'b1111;
        w_wdat = req_wdata;
      end
    endcase
  end

  // Clear and store are exclusive: requests are never accepted in CLEAR.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
        end
      end
    end
  end

  // ---------------- load path ----------------
  assign w_rword   = r_mem[w_idx];
  assign w_shifted = w_rword >> {req_addr[1:0], 3'b000};

  always_comb begin
    w_ldat = w_rword;
    case (req_funct3)
      3'b000:  w_ldat = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_ldat = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_ldat = {24'h0, w_shifted[7:0]};
      3'b101:  w_ldat = {16'h0, w_shifted[15:0]};
      default: w_ldat = w_rword;
    endcase
  end

  // ---------------- response ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_acc;
      r_rsp_err   <= w_acc && w_err;
      r_rsp_rdata <= (w_acc && !req_we && !w_err) ? w_ldat : '0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words stored (power of two, 4..65536).
REQ-002 SHALL have parameter CLEAR_ON_RESET, default 1, meaning zero every word after reset (1) or leave contents unchanged (0).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  meaning the request is present.
REQ-006 SHALL have port req_ready  output  1  meaning the block can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  meaning 1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  meaning the RV32I access size/sign code.
REQ-009 SHALL have port req_addr  input  32  meaning the byte address.
REQ-010 SHALL have port req_wdata  input  32  meaning the store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  meaning a one-cycle pulse marking the response.
REQ-012 SHALL have port rsp_rdata  output  32  meaning the extended load data.
REQ-013 SHALL have port rsp_err  output  1  meaning the request was rejected (misaligned, out of range or illegal funct3).
REQ-014 SHALL have port busy  output  1  meaning the clear sequence is in progress.

Function
REQ-015 SHALL implement FSM states CLEAR and READY; req_ready=1 only in READY; busy=1 only in CLEAR.
REQ-016 In CLEAR, SHALL write zero to word clr_idx each cycle, clr_idx counting 0..DEPTH-1, then go to READY on the cycle after writing DEPTH-1 (DEPTH cycles total).
REQ-017 SHALL accept a request on the edge where req_valid&&req_ready; no request queueing.
REQ-018 SHALL assert rsp_valid exactly one cycle after acceptance for exactly one cycle; back-to-back accepts give back-to-back responses; responses have no backpressure.
REQ-019 Word index SHALL be req_addr[31:2]; an index >= DEPTH SHALL set rsp_err=1.
REQ-020 Loads SHALL support funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores SHALL support 000 SB, 001 SH, 010 SW; all other codes SHALL set rsp_err=1.
REQ-021 Alignment: a halfword SHALL need addr[0]=0; a word SHALL need addr[1:0]=00; a violation SHALL set rsp_err=1.
REQ-022 A store SHALL write only the addressed byte lanes (lane = addr[1:0]), using the low bytes of req_wdata shifted to the lane, at the accept edge.
REQ-023 A load SHALL select bytes by addr[1:0]; LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend to 32 bits.
REQ-024 On rsp_err=1, or for any store, rsp_rdata SHALL be 0; an erroneous store SHALL not modify memory.
REQ-025 A load accepted the cycle after a store to the same word SHALL return the stored data (read-after-write visible next cycle).
REQ-026 Outside a response cycle, rsp_rdata and rsp_err SHALL be 0.

Reset
REQ-027 While rst=1: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, clr_idx=0.
REQ-028 While rst=1, state SHALL be CLEAR if CLEAR_ON_RESET=1, READY otherwise; busy follows REQ-015.
REQ-029 When rst asserts mid-clear or mid-response, the block SHALL abort at once, drop any pending response, and restart the clear from index 0 after rst deasserts.

Verification
REQ-030 Reset release, DEPTH=256, CLEAR_ON_RESET=1 -> busy=1 for exactly 256 cycles, then req_ready=1; LW 0x3FC -> rdata 0x00000000, err 0.
REQ-031 SW 0x10 data 0x8899AABB, then LB/LBU/LH/LHU at 0x13/0x13/0x12/0x12 -> 0xFFFFFF88, 0x00000088, 0xFFFF8899, 0x00008899.
REQ-032 SB 0x21 data 0x5A over word 0x11223344 at 0x20 -> LW 0x20 returns 0x11225A44.
REQ-033 SH 0x31 or LW 0x402 (DEPTH=256), or funct3 011 -> rsp_err=1, rdata 0, memory unchanged.
REQ-034 Store then load to the same word on consecutive cycles -> two consecutive rsp_valid pulses; the load returns the new data.
REQ-035 rst pulse during clear at clr_idx=100 -> after release busy is high for a full 256 cycles; rst during a pending load -> no rsp_valid.
